// File: rtl/seg7_blink_scan.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Per-digit blink mask, live decimal points, one dead cycle per slot, per-frame data latch.
module seg7_blink_scan #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_data,
  input  logic [7:0]  blink,
  input  logic [7:0]  dp_en,
  input  logic        en,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_TICKS - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [BW-1:0] bl_cnt_q, bl_cnt_d;
  logic          phase_q, phase_d;
  logic [31:0]   frame_q, frame_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick;
  logic [4:0]    nib_base;
  logic [3:0]    nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick       = (scan_cnt_q == SCAN_LAST);
    nib_base   = {dig_q, 2'b00};
    nib        = frame_q[nib_base +: 4];
    scan_cnt_d = scan_cnt_q;
    dig_d      = dig_q;
    bl_cnt_d   = bl_cnt_q;
    phase_d    = phase_q;
    frame_d    = frame_q;
    an_d       = 8'hFF;
    seg_d      = 8'hFF;
    if (tick) begin
      // Dead cycle: anodes and segments off while the digit index advances.
      scan_cnt_d = '0;
      dig_d      = dig_q + 3'd1;
      if (bl_cnt_q == BL_LAST) begin
        bl_cnt_d = '0;
        phase_d  = ~phase_q;
      end else begin
        bl_cnt_d = bl_cnt_q + 1'b1;
      end
      if (dig_q == 3'd7) frame_d = disp_data;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      an_d       = en ? ~(8'b1 << dig_q) : 8'hFF;
      seg_d      = (blink[dig_q] && phase_q) ? 8'hFF : {~dp_en[dig_q], hex7(nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dig_q      <= 3'd0;
      bl_cnt_q   <= '0;
      phase_q    <= 1'b0;
      frame_q    <= 32'h0;
      an_q       <= 8'hFF;
      seg_q      <= 8'hFF;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_q      <= dig_d;
      bl_cnt_q   <= bl_cnt_d;
      phase_q    <= phase_d;
      frame_q    <= frame_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_seg7_blink_scan.sv
// Bench for seg7_blink_scan: directed vector table, hand sequences and a random run
// checked every cycle against a cycle-count based reference model.
module tb_seg7_blink_scan;
  localparam int SD = 4;
  localparam int BT = 8;

  logic        clk, rst, en;
  logic [31:0] disp_data;
  logic [7:0]  blink, dp_en, AN, SEG;

  seg7_blink_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .disp_data(disp_data), .blink(blink),
    .dp_en(dp_en), .en(en), .AN(AN), .SEG(SEG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int c_m   = 0;          // cycles since reset release
  logic [31:0] frame_m = 32'h0;
  logic [6:0]  hex_tab [16];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  bl;
    logic [7:0]  dp;
    logic        en;
    int          frm;
    int          dig;
    int          sub;
    logic [7:0]  an;
    logic [7:0]  seg;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t c=%0d)", name, act, exp, $time, c_m);
    end
  endtask

  // One clock: predict outputs from the state reached after c_m cycles and current inputs.
  task automatic step();
    int sc, d, ph;
    logic [7:0] e_an, e_seg;
    logic [3:0] n;
    @(posedge clk);
    sc = c_m % SD;
    d  = (c_m / SD) % 8;
    ph = (c_m / (SD * BT)) % 2;
    n  = 4'((frame_m >> (4 * d)) & 32'hF);
    if (sc == SD - 1) begin
      e_an = 8'hFF; e_seg = 8'hFF;
    end else begin
      e_an  = en ? ~(8'h01 << d) : 8'hFF;
      e_seg = (blink[d] && ph == 1) ? 8'hFF : {~dp_en[d], hex_tab[n]};
    end
    #1;
    chk("model_an", AN, e_an);
    chk("model_seg", SEG, e_seg);
    chk("ghost", 8'($countones(~AN) > 1), 8'h00);
    if (sc == SD - 1 && d == 7) frame_m = disp_data;
    c_m++;
  endtask

  task automatic run_to(input int c);
    while (c_m < c) step();
    step();
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_an", AN, 8'hFF);
    chk("rst_async_seg", SEG, 8'hFF);
    @(posedge clk);
    #1;
    chk("rst_hold_an", AN, 8'hFF);
    chk("rst_hold_seg", SEG, 8'hFF);
    rst = 1'b0;
    c_m = 0;
    frame_m = 32'h0;
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst = 1'b1; en = 1'b1; disp_data = 32'h0; blink = 8'h0; dp_en = 8'h0;

    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b1, 0, 0, 0, 8'hFE, 8'hC0});
    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b1, 1, 0, 0, 8'hFE, 8'hF9});
    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b1, 1, 3, 0, 8'hF7, 8'h99});
    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b1, 1, 7, 0, 8'h7F, 8'h80});
    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b1, 1, 7, 2, 8'h7F, 8'h80});
    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b1, 1, 7, 3, 8'hFF, 8'hFF});
    vecs.push_back('{32'h87654321, 8'h01, 8'h00, 1'b1, 1, 0, 0, 8'hFE, 8'hFF});
    vecs.push_back('{32'h87654321, 8'h01, 8'h00, 1'b1, 2, 0, 1, 8'hFE, 8'hF9});
    vecs.push_back('{32'h87654321, 8'h01, 8'h00, 1'b1, 1, 1, 0, 8'hFD, 8'hA4});
    vecs.push_back('{32'h87654321, 8'hFF, 8'h00, 1'b1, 1, 5, 0, 8'hDF, 8'hFF});
    vecs.push_back('{32'h87654321, 8'h00, 8'h00, 1'b0, 1, 2, 0, 8'hFF, 8'hB0});
    vecs.push_back('{32'h87654321, 8'h00, 8'h04, 1'b1, 1, 2, 0, 8'hFB, 8'h30});
    vecs.push_back('{32'hFEDCBA09, 8'h00, 8'h00, 1'b1, 1, 0, 0, 8'hFE, 8'h90});
    vecs.push_back('{32'hFEDCBA09, 8'h00, 8'h00, 1'b1, 1, 2, 1, 8'hFB, 8'h88});
    vecs.push_back('{32'hFEDCBA09, 8'h00, 8'h00, 1'b1, 1, 3, 0, 8'hF7, 8'h83});
    vecs.push_back('{32'hFEDCBA09, 8'h00, 8'h00, 1'b1, 1, 4, 2, 8'hEF, 8'hC6});
    vecs.push_back('{32'hFEDCBA09, 8'h00, 8'h00, 1'b1, 1, 5, 0, 8'hDF, 8'hA1});
    vecs.push_back('{32'hFEDCBA09, 8'h00, 8'h00, 1'b1, 1, 6, 0, 8'hBF, 8'h86});

    #2;
    chk("reset_an", AN, 8'hFF);
    chk("reset_seg", SEG, 8'hFF);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      disp_data = vecs[i].data; blink = vecs[i].bl; dp_en = vecs[i].dp; en = vecs[i].en;
      do_reset();
      run_to(SD * 8 * vecs[i].frm + SD * vecs[i].dig + vecs[i].sub);
      chk($sformatf("vec%0d_an", i), AN, vecs[i].an);
      chk($sformatf("vec%0d_seg", i), SEG, vecs[i].seg);
    end

    // Mid-frame data change is held off until the next frame boundary.
    disp_data = 32'h87654321; blink = 8'h00; dp_en = 8'h00; en = 1'b1;
    do_reset();
    run_to(32 + 12);
    disp_data = 32'hFFFFFFFF;
    for (int d = 4; d < 8; d++) begin
      run_to(32 + SD * d + 1);
      chk("midframe_an", AN, ~(8'h01 << d));
      chk("midframe_seg", SEG, {1'b1, hex_tab[d + 1]});
    end
    run_to(64 + 1);
    chk("newframe_seg", SEG, 8'h8E);

    // Reset while a digit is lit, then the scan restarts from digit 0 with a cleared frame.
    run_to(64 + SD * 5 + 1);
    do_reset();
    run_to(1);
    chk("restart_an", AN, 8'hFE);
    chk("restart_seg", SEG, 8'hC0);

    // Random run, every cycle compared with the model.
    for (int k = 0; k < 3000; k++) begin
      step();
      if ($urandom_range(0, 15) == 0) disp_data = $urandom;
      if ($urandom_range(0, 7) == 0) blink = 8'($urandom);
      if ($urandom_range(0, 7) == 0) dp_en = 8'($urandom);
      if ($urandom_range(0, 7) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
